vga_timing_gen: RTL and testbench

Pixel-clock video timing generator and pixel sourcer that drives the HDMI transmitter's VGA-style input (HSYNC, VSYNC, DE, 24-bit RGB). It produces 640x480@60 timing by default. During active video it pops pixels from an upstream frame-buffer read FIFO, or substitutes an internal 8-bar colour pattern. FIFO underflow is flagged. The block runs entirely in the 25 MHz pixel clock domain.

---
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Purpose : 640x480@60-style video timing generator with FIFO or colour-bar pixel source.
// Latency : 2 cycles from counter state to HS/VS/DE/RGB/FRAME_START; FIFO data 1 cycle after pop.
// Backpr. : no stall; an empty FIFO during active video outputs black and sets UNDERFLOW_O.
//
// Ports:
//   PXLCLK_I, RSTN_I (sync, active-low)   - pixel clock and reset
//   PATTERN_EN_I                          - 1 = colour bars, 0 = FIFO pixels (latched per frame)
//   FIFO_EMPTY_I, FIFO_DATA_I, FIFO_RD_O  - upstream read FIFO, 1-cycle read latency
//   VGA_HS_O, VGA_VS_O, VGA_DE_O, VGA_RGB_O - transmitter video interface
//   FRAME_START_O                         - pulse with output pixel (0,0)
//   UNDERFLOW_O                           - sticky per frame, set on any starved active pixel
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        PXLCLK_I,
    input  logic        RSTN_I,
    input  logic        PATTERN_EN_I,
    input  logic        FIFO_EMPTY_I,
    input  logic [23:0] FIFO_DATA_I,
    output logic        FIFO_RD_O,
    output logic        VGA_HS_O,
    output logic        VGA_VS_O,
    output logic        VGA_DE_O,
    output logic [23:0] VGA_RGB_O,
    output logic        FRAME_START_O,
    output logic        UNDERFLOW_O
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    // Thresholds carry one extra bit so a zero back porch cannot wrap the sync end.
    localparam logic [HW:0]   H_ACT_END = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   HS_BEG    = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   HS_END    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   V_ACT_END = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   VS_BEG    = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   VS_END    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [BW-1:0] BAR_LAST  = BW'(BAR_W - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [BW-1:0] bar_w;
    logic [2:0]    bar_idx;
    logic          pat_q;

    // stage 0 decode
    logic          h_act, active, hs_act, vs_act, fs0, starve0, pop0;
    logic          line_last, frame_last;
    logic [23:0]   bar_rgb;

    // stage 1 registers
    logic          s1_de, s1_hs, s1_vs, s1_fs, s1_pop, s1_starve;
    logic [23:0]   s1_rgb;

    always_comb begin
        h_act      = {1'b0, h_cnt} < H_ACT_END;
        active     = h_act && ({1'b0, v_cnt} < V_ACT_END);
        hs_act     = ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
        vs_act     = ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);
        fs0        = (h_cnt == '0) && (v_cnt == '0);
        line_last  = (h_cnt == H_LAST);
        frame_last = line_last && (v_cnt == V_LAST);
        starve0    = active && !pat_q && FIFO_EMPTY_I;
        pop0       = active && !pat_q && !FIFO_EMPTY_I;
    end

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    // Counters sit at (0,0) while in reset, so the pop must also be gated by
    // the reset input itself or the FIFO would drain during reset.
    assign FIFO_RD_O = RSTN_I && pop0;

    always_ff @(posedge PXLCLK_I) begin
        if (!RSTN_I) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_w   <= '0;
            bar_idx <= '0;
        end else begin
            if (line_last) begin
                h_cnt   <= '0;
                v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                bar_w   <= '0;
                bar_idx <= '0;
            end else begin
                h_cnt <= h_cnt + 1'b1;
                // bar position tracks h_cnt across the active part of the line
                if (h_act) begin
                    if (bar_w == BAR_LAST) begin
                        bar_w   <= '0;
                        bar_idx <= bar_idx + 1'b1;
                    end else begin
                        bar_w <= bar_w + 1'b1;
                    end
                end
            end
        end
    end

    // Source select only changes on the last pixel of a frame (or in reset),
    // so a frame is never a mix of bars and FIFO data.
    always_ff @(posedge PXLCLK_I) begin
        if (!RSTN_I || frame_last) begin
            pat_q <= PATTERN_EN_I;
        end
    end

    always_ff @(posedge PXLCLK_I) begin
        if (!RSTN_I) begin
            s1_de     <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_fs     <= 1'b0;
            s1_pop    <= 1'b0;
            s1_starve <= 1'b0;
            s1_rgb    <= '0;
        end else begin
            s1_de     <= active;
            s1_hs     <= hs_act;
            s1_vs     <= vs_act;
            s1_fs     <= fs0;
            s1_pop    <= pop0;
            s1_starve <= starve0;
            s1_rgb    <= (active && pat_q) ? bar_rgb : 24'h000000;
        end
    end

    always_ff @(posedge PXLCLK_I) begin
        if (!RSTN_I) begin
            VGA_HS_O      <= !HS_POL;
            VGA_VS_O      <= !VS_POL;
            VGA_DE_O      <= 1'b0;
            VGA_RGB_O     <= '0;
            FRAME_START_O <= 1'b0;
            UNDERFLOW_O   <= 1'b0;
        end else begin
            VGA_HS_O      <= s1_hs ? HS_POL : !HS_POL;
            VGA_VS_O      <= s1_vs ? VS_POL : !VS_POL;
            VGA_DE_O      <= s1_de;
            // FIFO data arrives this cycle for a pop issued last cycle
            VGA_RGB_O     <= s1_pop ? FIFO_DATA_I : s1_rgb;
            FRAME_START_O <= s1_fs;
            // a starved first pixel keeps the flag set
            if (s1_starve) begin
                UNDERFLOW_O <= 1'b1;
            end else if (s1_fs) begin
                UNDERFLOW_O <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 64;
    localparam int H_FP     = 4;
    localparam int H_SYNC   = 8;
    localparam int H_BP     = 6;
    localparam int V_ACTIVE = 10;
    localparam int V_FP     = 2;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 3;
    localparam bit HS_POL   = 1'b0;
    localparam bit VS_POL   = 1'b1;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = HT * VT;
    localparam int BARW     = H_ACTIVE / 8;

    localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        rstn;
    logic        pat_en;
    logic        fifo_empty;
    logic [23:0] fifo_data;
    logic        fifo_rd;
    logic        hs, vs, de, fs, uf;
    logic [23:0] rgb;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .PXLCLK_I      (clk),
        .RSTN_I        (rstn),
        .PATTERN_EN_I  (pat_en),
        .FIFO_EMPTY_I  (fifo_empty),
        .FIFO_DATA_I   (fifo_data),
        .FIFO_RD_O     (fifo_rd),
        .VGA_HS_O      (hs),
        .VGA_VS_O      (vs),
        .VGA_DE_O      (de),
        .VGA_RGB_O     (rgb),
        .FRAME_START_O (fs),
        .UNDERFLOW_O   (uf)
    );

    typedef struct packed {
        logic [31:0] k;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        starve;
        logic [23:0] rgb;
    } pix_t;

    localparam pix_t RST_PIX = '{k: 32'hFFFFFFFF, hs: !HS_POL, vs: !VS_POL,
                                 de: 1'b0, fs: 1'b0, starve: 1'b0, rgb: 24'h0};

    int   checks = 0;
    int   errors = 0;
    int   pos = 0;            // frame position of the pixel being decoded this cycle
    bit   mpat = 1'b1;        // source choice for the current frame
    bit   uf_m = 1'b0;
    pix_t p1 = RST_PIX;
    pix_t p2 = RST_PIX;       // what the outputs should show now
    int   next_val = 1;       // value at the FIFO head
    int   cnt_de, cnt_fs, cnt_hs, cnt_vs, cnt_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic pix_t expect_pixel(input int k, input bit pat, input bit empty,
                                          input logic [23:0] front);
        pix_t p;
        int x, y;
        bit act;
        x = k % HT;
        y = k / HT;
        act = (x < H_ACTIVE) && (y < V_ACTIVE);
        p.k      = 32'(k);
        p.hs     = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
        p.vs     = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
        p.de     = act;
        p.fs     = (k == 0);
        p.starve = act && !pat && empty;
        if (!act)       p.rgb = 24'h0;
        else if (pat)   p.rgb = BARS[x / BARW];
        else if (empty) p.rgb = 24'h0;
        else            p.rgb = front;
        return p;
    endfunction

    // One clock: inputs for this cycle are already applied on entry.
    task automatic cycle();
        pix_t e0;
        bit   rd_exp, act;
        logic rd_seen;
        #1;
        act    = ((pos % HT) < H_ACTIVE) && ((pos / HT) < V_ACTIVE);
        rd_exp = rstn && act && !mpat && !fifo_empty;
        chk("fifo_rd", 32'(fifo_rd), 32'(rd_exp));
        e0      = expect_pixel(pos, mpat, fifo_empty, next_val[23:0]);
        rd_seen = fifo_rd;
        @(posedge clk);
        #1;
        if (!rstn) begin
            p1   = RST_PIX;
            p2   = RST_PIX;
            uf_m = 1'b0;
            pos  = 0;
            mpat = pat_en;
        end else begin
            p2 = p1;
            p1 = e0;
            if (p2.fs)          uf_m = p2.starve;
            else if (p2.starve) uf_m = 1'b1;
            if (pos == FRAME - 1) mpat = pat_en;
            pos = (pos + 1) % FRAME;
        end
        if (rd_seen === 1'b1) begin
            fifo_data = next_val[23:0];
            next_val++;
            cnt_pop++;
        end else begin
            fifo_data = 24'($urandom);
        end
        chk("hs",  32'(hs),  32'(p2.hs));
        chk("vs",  32'(vs),  32'(p2.vs));
        chk("de",  32'(de),  32'(p2.de));
        chk("fs",  32'(fs),  32'(p2.fs));
        chk("rgb", 32'(rgb), 32'(p2.rgb));
        chk("underflow", 32'(uf), 32'(uf_m));
        if (de === 1'b1) cnt_de++;
        if (fs === 1'b1) cnt_fs++;
        if (hs === HS_POL) cnt_hs++;
        if (vs === VS_POL) cnt_vs++;
    endtask

    task automatic run_to_pos(input int target);
        int n = 0;
        while (pos != target && n < 2 * FRAME) begin
            cycle();
            n++;
        end
        chk("reach_pos", 32'(pos), 32'(target));
    endtask

    task automatic run_until_out(input int target);
        int n = 0;
        while (p2.k != 32'(target) && n < 2 * FRAME) begin
            cycle();
            n++;
        end
        chk("reach_out", p2.k, 32'(target));
    endtask

    task automatic count_frame(input bit fifo_mode);
        cnt_de = 0; cnt_fs = 0; cnt_hs = 0; cnt_vs = 0; cnt_pop = 0;
        repeat (FRAME) cycle();
        chk("de_per_frame", 32'(cnt_de), 32'(H_ACTIVE * V_ACTIVE));
        chk("fs_per_frame", 32'(cnt_fs), 32'd1);
        chk("hs_per_frame", 32'(cnt_hs), 32'(H_SYNC * VT));
        chk("vs_per_frame", 32'(cnt_vs), 32'(V_SYNC * HT));
        chk("pops_per_frame", 32'(cnt_pop), fifo_mode ? 32'(H_ACTIVE * V_ACTIVE) : 32'd0);
    endtask

    task automatic check_reset_values();
        chk("rst_hs",  32'(hs),  32'(!HS_POL));
        chk("rst_vs",  32'(vs),  32'(!VS_POL));
        chk("rst_de",  32'(de),  32'd0);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_fs",  32'(fs),  32'd0);
        chk("rst_uf",  32'(uf),  32'd0);
        chk("rst_rd",  32'(fifo_rd), 32'd0);
    endtask

    initial begin
        rstn       = 1'b0;
        pat_en     = 1'b1;
        fifo_empty = 1'b0;
        fifo_data  = 24'h0;

        // reset, then colour bars
        repeat (3) cycle();
        check_reset_values();
        rstn = 1'b1;
        cycle();
        chk("no_fs_after_1st_edge", 32'(fs), 32'd0);
        cycle();
        chk("fs_after_2nd_edge", 32'(fs), 32'd1);
        chk("de_after_2nd_edge", 32'(de), 32'd1);
        chk("bar_px0", 32'(rgb), 32'h00FFFFFF);
        run_until_out(BARW - 1);
        chk("bar_last_of_bar0", 32'(rgb), 32'h00FFFFFF);
        run_until_out(BARW);
        chk("bar_first_of_bar1", 32'(rgb), 32'h00FFFF00);
        run_until_out(6 * BARW);
        chk("bar6", 32'(rgb), 32'h000000FF);
        run_until_out(H_ACTIVE - 1);
        chk("bar_last_px", 32'(rgb), 32'h00000000);
        chk("bar_last_de", 32'(de), 32'd1);
        run_until_out(H_ACTIVE);
        chk("blank_de", 32'(de), 32'd0);
        count_frame(1'b0);

        // switch to FIFO mid-frame: takes effect at next frame start
        run_to_pos(5 * HT + 10);
        pat_en = 1'b0;
        run_until_out(5 * HT + 20);
        chk("still_bars", 32'(rgb), 32'(BARS[20 / BARW]));
        run_until_out(0);
        chk("fifo_frame_fs", 32'(fs), 32'd1);
        count_frame(1'b1);
        chk("no_underflow", 32'(uf), 32'd0);

        // five starved pixels mid-line
        run_to_pos(4 * HT + 20);
        fifo_empty = 1'b1;
        cycle();
        chk("starve_no_pop", 32'(fifo_rd), 32'd0);
        repeat (4) cycle();
        fifo_empty = 1'b0;
        cycle();
        chk("starve_rgb0", 32'(rgb), 32'd0);
        chk("uf_set", 32'(uf), 32'd1);
        run_until_out(0);
        chk("uf_cleared", 32'(uf), 32'd0);

        // random empties and source toggles
        repeat (2 * FRAME) begin
            fifo_empty = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) pat_en = !pat_en;
            cycle();
        end
        fifo_empty = 1'b0;

        // reset mid-frame
        run_to_pos(7 * HT + 40);
        rstn = 1'b0;
        repeat (3) cycle();
        check_reset_values();
        rstn   = 1'b1;
        pat_en = 1'b1;
        cycle();
        cycle();
        chk("fs_after_mid_reset", 32'(fs), 32'd1);
        count_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
